// File: rtl/ml_acc_pkg.sv
// Shared constants and types for the memory-mapped MAC accelerator:
// bus address map, register offsets, status bits and FSM/read-source enums.
package ml_acc_pkg;

    localparam logic [31:0] X_BASE = 32'h4000_0000;
    localparam logic [31:0] W_BASE = 32'h4200_0000;
    localparam logic [31:0] R_BASE = 32'h43C0_0000;

    // Word-granular bases; address bits [1:0] never take part in decode.
    localparam logic [29:0] X_WBASE = X_BASE[31:2];
    localparam logic [29:0] W_WBASE = W_BASE[31:2];
    localparam logic [29:0] R_WBASE = R_BASE[31:2];

    localparam int NUM_REGS = 16;

    localparam logic [3:0] REG_CTRL      = 4'd10;
    localparam logic [3:0] REG_STATUS    = 4'd11;
    localparam logic [3:0] REG_RESULT_LO = 4'd12;
    localparam logic [3:0] REG_RESULT_HI = 4'd13;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef enum logic [1:0] {SRC_ZERO, SRC_X, SRC_W, SRC_REG} rd_src_t;

endpackage

// File: rtl/ml_acc_bram.sv
// Single-port synchronous RAM, one-cycle read latency, no reset on contents.
module ml_acc_bram #(
    parameter int RAM_DEPTH = 32,
    parameter int AW        = 5
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/ml_acc_system.sv
// MAC accelerator top: bus decode, run-control FSM, 64-bit signed MAC pipeline
// and registered read-data path in front of two ml_acc_bram instances.
module ml_acc_system
    import ml_acc_pkg::*;
#(
    parameter int N_TAPS    = 25,
    parameter int RAM_DEPTH = 32
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] bus_addr,
    input  logic        bus_wr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_rd,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        irq_done
);

    localparam int            AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

    logic [29:0]   word_addr, x_off, w_off, r_off;
    logic          hit_x, hit_w, hit_r;
    logic [3:0]    r_idx;
    logic          unused_addr_bits;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          idle, start, issue, finish, rd_go;

    logic          x_en, x_we, w_en, w_we;
    logic [AW-1:0] x_addr, w_addr;
    logic [31:0]   x_rd, w_rd;

    logic signed [63:0] w_ext, x_ext, prod_p2_q, acc_q, result_q;
    logic          vld_p1_q, vld_p2_q, done_q;

    logic [31:0]   reg_val;
    rd_src_t       rd_src_d, rd_src_p1_q;
    logic          rd_vld_p1_q;
    logic [31:0]   rd_reg_p1_q, bus_rdata_q;
    logic          bus_rvalid_q;

    assign word_addr        = bus_addr[31:2];
    assign unused_addr_bits = ^bus_addr[1:0];
    assign x_off            = word_addr - X_WBASE;
    assign w_off            = word_addr - W_WBASE;
    assign r_off            = word_addr - R_WBASE;
    assign hit_x            = x_off < 30'(RAM_DEPTH);
    assign hit_w            = w_off < 30'(RAM_DEPTH);
    assign hit_r            = r_off < 30'(NUM_REGS);
    assign r_idx            = r_off[3:0];

    assign idle  = (state_q == IDLE);
    assign start = idle && bus_wr && hit_r && (r_idx == REG_CTRL) && bus_wdata[0];
    assign rd_go = bus_rd && !bus_wr;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DRAIN waits for the last product to leave the multiplier register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                issue = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_TAP) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_p2_q && !vld_p1_q) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Host owns the RAM ports only while idle; the engine owns them otherwise.
    assign x_en   = idle ? (hit_x && (bus_wr || bus_rd)) : issue;
    assign w_en   = idle ? (hit_w && (bus_wr || bus_rd)) : issue;
    assign x_we   = idle && hit_x && bus_wr;
    assign w_we   = idle && hit_w && bus_wr;
    assign x_addr = idle ? x_off[AW-1:0] : cnt_q;
    assign w_addr = idle ? w_off[AW-1:0] : cnt_q;

    ml_acc_bram #(.RAM_DEPTH(RAM_DEPTH), .AW(AW)) u_xram (
        .clk_i   (ACLK),
        .en_i    (x_en),
        .we_i    (x_we),
        .addr_i  (x_addr),
        .wdata_i (bus_wdata),
        .rdata_o (x_rd)
    );

    ml_acc_bram #(.RAM_DEPTH(RAM_DEPTH), .AW(AW)) u_wram (
        .clk_i   (ACLK),
        .en_i    (w_en),
        .we_i    (w_we),
        .addr_i  (w_addr),
        .wdata_i (bus_wdata),
        .rdata_o (w_rd)
    );

    assign w_ext = {{32{w_rd[31]}}, w_rd};
    assign x_ext = {{32{x_rd[31]}}, x_rd};

    // p1 -> p2: RAM outputs valid, register the full 64-bit product
    always_ff @(posedge ACLK) begin
        if (vld_p1_q) begin
            prod_p2_q <= w_ext * x_ext;
        end
    end

    // p2: accumulate, wrapping modulo 2^64
    always_ff @(posedge ACLK) begin
        if (start) begin
            acc_q <= '0;
        end else if (vld_p2_q) begin
            acc_q <= acc_q + prod_p2_q;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            vld_p1_q <= issue;
            vld_p2_q <= vld_p1_q;
            if (start) begin
                done_q <= 1'b0;
            end else if (finish) begin
                done_q   <= 1'b1;
                result_q <= acc_q + prod_p2_q;
            end
        end
    end

    always_comb begin
        reg_val = '0;
        case (r_idx)
            REG_STATUS: begin
                reg_val[ST_BUSY] = !idle;
                reg_val[ST_DONE] = done_q;
            end
            REG_RESULT_LO: reg_val = result_q[31:0];
            REG_RESULT_HI: reg_val = result_q[63:32];
            default:       reg_val = '0;
        endcase
    end

    // RAM reads issued while busy are answered with zero.
    always_comb begin
        rd_src_d = SRC_ZERO;
        if (hit_x && idle) begin
            rd_src_d = SRC_X;
        end else if (hit_w && idle) begin
            rd_src_d = SRC_W;
        end else if (hit_r) begin
            rd_src_d = SRC_REG;
        end
    end

    // p0 -> p1: capture the read request; p1 -> out: mux RAM or register data
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_vld_p1_q  <= 1'b0;
            rd_src_p1_q  <= SRC_ZERO;
            rd_reg_p1_q  <= '0;
            bus_rdata_q  <= '0;
            bus_rvalid_q <= 1'b0;
        end else begin
            rd_vld_p1_q  <= rd_go;
            rd_src_p1_q  <= rd_src_d;
            rd_reg_p1_q  <= reg_val;
            bus_rvalid_q <= rd_vld_p1_q;
            if (rd_vld_p1_q) begin
                case (rd_src_p1_q)
                    SRC_X:   bus_rdata_q <= x_rd;
                    SRC_W:   bus_rdata_q <= w_rd;
                    SRC_REG: bus_rdata_q <= rd_reg_p1_q;
                    default: bus_rdata_q <= '0;
                endcase
            end
        end
    end

    assign bus_rdata  = bus_rdata_q;
    assign bus_rvalid = bus_rvalid_q;
    assign irq_done   = done_q;

endmodule

// File: tb/tb_ml_acc_system.sv
// Directed bench for ml_acc_system: read responses are checked through a
// scoreboard queue, run timing is checked cycle by cycle against irq_done.
module tb_ml_acc_system;

    localparam int N = 25;
    localparam int D = 32;
    localparam logic [31:0] XB = 32'h4000_0000;
    localparam logic [31:0] WB = 32'h4200_0000;
    localparam logic [31:0] RB = 32'h43C0_0000;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] bus_addr = '0;
    logic        bus_wr = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic        bus_rd = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        irq_done;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    ml_acc_system #(.N_TAPS(N), .RAM_DEPTH(D)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .bus_addr   (bus_addr),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .irq_done   (irq_done)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge ACLK) begin : monitor
        string       t;
        logic [31:0] e;
        if (bus_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_rvalid: observed rdata=%h expected no response", bus_rdata);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                chk(t, bus_rdata, e);
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge ACLK);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1; bus_rd = 1'b0;
        @(negedge ACLK);
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string t);
        @(negedge ACLK);
        bus_addr = a; bus_rd = 1'b1; bus_wr = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge ACLK);
        bus_rd = 1'b0;
        @(negedge ACLK);
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_latency: observed pending=%0d expected 0", t, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // mode 0 plain run, 1 second start at cycle 5, 2 RAM write/read at cycles 5/7,
    // 3 reset pulse at cycle 10.
    task automatic run(input int mode, input logic [31:0] elo, input logic [31:0] ehi, input string t);
        bit aborted = 1'b0;
        @(negedge ACLK);
        bus_addr = RB + 32'h28; bus_wdata = 32'h1; bus_wr = 1'b1; bus_rd = 1'b0;
        @(posedge ACLK);
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge ACLK);
            bus_wr = 1'b0; bus_rd = 1'b0;
            chk({t, "_irq_while_busy"}, {31'b0, irq_done}, 32'h0);
            if (c == 3) begin
                bus_addr = RB + 32'h2C; bus_rd = 1'b1;
                exp_q.push_back(32'h1);
                tag_q.push_back({t, "_status_busy"});
            end
            if (mode == 1 && c == 5) begin
                bus_addr = RB + 32'h28; bus_wdata = 32'h1; bus_wr = 1'b1;
            end
            if (mode == 2 && c == 5) begin
                bus_addr = XB; bus_wdata = 32'h1234_5678; bus_wr = 1'b1;
            end
            if (mode == 2 && c == 7) begin
                bus_addr = XB + 32'h4; bus_rd = 1'b1;
                exp_q.push_back(32'h0);
                tag_q.push_back({t, "_ram_read_busy"});
            end
            if (mode == 3 && c == 10) begin
                ARESET = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(posedge ACLK);
        end
        if (aborted) begin
            @(posedge ACLK);
            @(negedge ACLK);
            ARESET = 1'b0;
            chk({t, "_irq_after_reset"}, {31'b0, irq_done}, 32'h0);
            bus_read(RB + 32'h2C, 32'h0, {t, "_status_after_reset"});
            bus_read(RB + 32'h30, 32'h0, {t, "_lo_after_reset"});
            bus_read(RB + 32'h34, 32'h0, {t, "_hi_after_reset"});
        end else begin
            @(negedge ACLK);
            chk({t, "_irq_done_at_T+27"}, {31'b0, irq_done}, 32'h1);
            bus_read(RB + 32'h2C, 32'h2, {t, "_status_done"});
            bus_read(RB + 32'h30, elo, {t, "_result_lo"});
            bus_read(RB + 32'h34, ehi, {t, "_result_hi"});
        end
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        chk("reset_rvalid", {31'b0, bus_rvalid}, 32'h0);
        chk("reset_rdata", bus_rdata, 32'h0);
        chk("reset_irq", {31'b0, irq_done}, 32'h0);
        bus_read(RB + 32'h2C, 32'h0, "reset_status");
        bus_read(RB + 32'h30, 32'h0, "reset_result_lo");
        bus_read(RB + 32'h34, 32'h0, "reset_result_hi");

        bus_write(XB, 32'hDEAD_BEEF);
        bus_read(XB, 32'hDEAD_BEEF, "x0_readback");

        @(negedge ACLK);
        bus_addr = XB + 32'h8; bus_wdata = 32'hA5A5_A5A5; bus_wr = 1'b1; bus_rd = 1'b1;
        @(negedge ACLK);
        bus_wr = 1'b0; bus_rd = 1'b0;
        repeat (2) @(negedge ACLK);
        bus_read(XB + 32'h8, 32'hA5A5_A5A5, "rdwr_write_kept");

        bus_write(XB + 32'h80, 32'h55);
        bus_read(XB, 32'hDEAD_BEEF, "x_oob_no_alias");
        bus_read(XB + 32'h80, 32'h0, "x_oob_read");
        bus_read(WB + 32'h80, 32'h0, "w_oob_read");
        bus_read(RB + 32'h28, 32'h0, "ctrl_reads_zero");
        bus_read(RB + 32'h14, 32'h0, "reg5_reads_zero");
        bus_read(32'h5000_0000, 32'h0, "unmapped_read");
        bus_write(RB + 32'h2C, 32'h3);
        bus_read(RB + 32'h2C, 32'h0, "status_read_only");

        for (int k = 0; k < D; k++) begin
            bus_write(WB + 32'(4 * k), 32'(k));
            bus_write(XB + 32'(4 * k), 32'h1);
        end
        bus_read(WB + 32'h1C, 32'h7, "w7_readback");
        run(0, 32'd300, 32'h0, "ramp_x1");

        for (int k = 0; k < D; k++) bus_write(XB + 32'(4 * k), 32'(k));
        run(0, 32'd4900, 32'h0, "ramp_sq");

        for (int k = 0; k < D; k++) begin
            bus_write(WB + 32'(4 * k), 32'hFFFF_FFFF);
            bus_write(XB + 32'(4 * k), 32'h2);
        end
        run(0, 32'hFFFF_FFCE, 32'hFFFF_FFFF, "neg");

        for (int k = 0; k < D; k++) begin
            bus_write(WB + 32'(4 * k), 32'h8000_0000);
            bus_write(XB + 32'(4 * k), 32'h8000_0000);
        end
        run(0, 32'h0, 32'h4000_0000, "wrap");

        for (int k = 0; k < D; k++) begin
            bus_write(WB + 32'(4 * k), 32'(k));
            bus_write(XB + 32'(4 * k), 32'h1);
        end
        run(1, 32'd300, 32'h0, "restart_ignored");
        run(2, 32'd300, 32'h0, "ram_busy");
        bus_read(XB, 32'h1, "ram_write_busy_dropped");

        run(3, 32'h0, 32'h0, "abort");
        run(0, 32'd300, 32'h0, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ml_acc_system.md
# ml_acc_system

Memory-mapped multiply-accumulate accelerator for the ML-acceleration subsystem. It sits behind the processor's general-purpose register bus. The host fills a weight RAM and an input RAM with signed 32-bit words, then writes control register 10 to start. The block computes the signed 64-bit dot product of the first `N_TAPS` entries and reports status and the result through registers.

## Interface
- `N_TAPS`, 25: number of products accumulated per run (1..`RAM_DEPTH`).
- `RAM_DEPTH`, 32: words per RAM.
- `ACLK`  in  1: sole clock; all state changes on its rising edge.
- `ARESET`  in  1: asynchronous, active-high reset.
- `bus_addr`  in  32: byte address, word-aligned; bits [1:0] are ignored.
- `bus_wr`  in  1: write strobe, one cycle per access.
- `bus_wdata`  in  32: write data.
- `bus_rd`  in  1: read strobe, one cycle per access.
- `bus_rdata`  out  32: read data.
- `bus_rvalid`  out  1: one-cycle pulse marking `bus_rdata` valid.
- `irq_done`  out  1: level copy of the status done bit.

## Operation
- Address map (full 32-bit decode):
  - Input RAM: 0x4000_0000 + 4·k.
  - Weight RAM: 0x4200_0000 + 4·k, with k < `RAM_DEPTH`.
  - Register file: 0x43C0_0000 + 4·r.
- Registers:
  - r10 (0x28) CTRL: writing bit0 = 1 starts a run (self-clearing, reads 0).
  - r11 (0x2C) STATUS, read-only: bit0 busy, bit1 done.
  - r12 (0x30) RESULT_LO, read-only.
  - r13 (0x34) RESULT_HI, read-only.
  - Other r in 0..15: read 0, writes ignored.
- Unmapped addresses: writes ignored, reads return 0 with `bus_rvalid` still pulsed.
- Run: acc = Σ_{k=0}^{N_TAPS-1} sext64(W[k]) · sext64(X[k]), using a full 64-bit signed product and a 64-bit accumulator that wraps modulo 2^64.
- States:
  - IDLE → RUN on start.
  - RUN: issues RAM reads k = 0..N_TAPS-1 on consecutive cycles.
  - RUN → DRAIN after the last read. DRAIN accumulates the final product.
  - DRAIN → IDLE: latches acc into RESULT and sets done.
- A start clears done and the accumulator. RESULT holds the last completed value until the next completion.
- A start while busy is ignored.
- Host RAM writes while busy are ignored. Host RAM reads while busy return 0.
- RAM contents are not affected by reset.

## Timing
- Write takes effect on the edge where `bus_wr` = 1.
- Read: `bus_rd` sampled at edge T; `bus_rdata` and `bus_rvalid` valid after edge T+1.
- `bus_rd` and `bus_wr` together: the write is performed, the read is dropped, and `bus_rvalid` stays 0.
- Start accepted at edge T:
  - busy = 1 from T+1.
  - done = 1, busy = 0 and RESULT valid from edge T+N_TAPS+2 (T+27 by default).
- Reset values: state IDLE, busy 0, done 0, RESULT 0, `bus_rdata` 0, `bus_rvalid` 0, `irq_done` 0.
- Reset asserted mid-run aborts the run immediately. Outputs take their reset values and RESULT reads 0.

## Structure
- Package `ml_acc_pkg`:
  - Base addresses.
  - Register offsets (CTRL = 10, STATUS = 11, RESULT_LO = 12, RESULT_HI = 13).
  - STATUS bit positions.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module `ml_acc_bram`:
  - Single-port 32-bit × `RAM_DEPTH` synchronous RAM, no reset, read latency 1.
  - Instantiated twice (weights, inputs).
  - Port muxed between host bus (IDLE) and engine (RUN).
- Top holds address decode, control FSM, MAC datapath and the read-data mux.

## Test plan
- Write 0xDEADBEEF to 0x4000_0000; read back → 0xDEADBEEF, with `bus_rvalid` one cycle after `bus_rd`.
- W[k] = k, X[k] = 1 for k < 25; write 1 to 0x43C0_0028 → after 27 cycles, STATUS = 0x2, RESULT_LO = 300, RESULT_HI = 0.
- W[k] = k, X[k] = k → RESULT = 4900.
- W[k] = 0xFFFF_FFFF (−1), X[k] = 2 → RESULT_LO = 0xFFFF_FFCE, RESULT_HI = 0xFFFF_FFFF.
- W[k] = X[k] = 0x8000_0000 → 25·2^62 wraps to RESULT_HI = 0x4000_0000, RESULT_LO = 0.
- Busy-window checks:
  - Second start at cycle 5 of a run → ignored; completion time and result unchanged.
  - RAM write during the run → not stored.
  - ARESET pulse at cycle 10 → STATUS = 0, RESULT = 0, and a fresh start completes correctly.
